// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter
// Shares one fpnew_top between NUM_REQ requesters. Issue side: round-robin
// arbitration with a grant lock while the FPU stalls. Return side: results come
// back in order, so a FIFO of requester IDs steers each one to the requester
// that issued it.
module fpu_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*3*WIDTH-1:0] req_operands_i,
    input  logic [NUM_REQ*4-1:0]       req_op_i,
    input  logic [NUM_REQ*3-1:0]       req_rnd_i,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    input  logic [NUM_REQ-1:0]         rsp_ready_i,
    output logic [WIDTH-1:0]           rsp_result_o,
    output logic [4:0]                 rsp_status_o,
    output logic [3*WIDTH-1:0]         fpu_operands_o,
    output logic [3:0]                 fpu_op_o,
    output logic [2:0]                 fpu_rnd_o,
    output logic                       fpu_in_valid_o,
    input  logic                       fpu_in_ready_i,
    input  logic [WIDTH-1:0]           fpu_result_i,
    input  logic [4:0]                 fpu_status_i,
    input  logic                       fpu_out_valid_i,
    output logic                       fpu_out_ready_o,
    input  logic                       flush_i,
    output logic                       fpu_flush_o,
    output logic                       idle_o,
    output logic                       err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        LOCK_OPEN,
        LOCK_HELD
    } lockState_e;

    lockState_e       state_q, state_d;
    logic [IDX_W-1:0] lockIdx_q, lockIdx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idFifo_q [MAX_OUT];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [IDX_W:0]   rrCand;
    logic [IDX_W-1:0] rrIdx;
    logic             rrFound;
    logic [IDX_W-1:0] grantIdx;
    logic             anyValid;
    logic             lockedValid;
    logic             lockDropped;
    logic             issueAllowed;
    logic             issueFire;
    logic             returnFire;
    logic             fifoEmpty;
    logic             strayResult;
    logic [IDX_W-1:0] headIdx;

    assign fifoEmpty    = (count_q == '0);
    assign headIdx      = idFifo_q[rdPtr_q];
    assign lockedValid  = req_valid_i[lockIdx_q];
    assign lockDropped  = (state_q == LOCK_HELD) && !lockedValid;
    // Reset is folded in so that every handshake output is quiet while rst_ni is low.
    assign issueAllowed = rst_ni && !flush_i && (count_q < CNT_W'(MAX_OUT));
    assign issueFire    = fpu_in_valid_o && fpu_in_ready_i;
    assign returnFire   = fpu_out_valid_i && fpu_out_ready_o && !fifoEmpty && !flush_i;
    assign strayResult  = fpu_out_valid_i && fifoEmpty && !flush_i;
    assign err_o        = err_q;

    // Round-robin search: first valid requester at or after ptr, wrapping around.
    always_comb begin
        rrIdx   = ptr_q;
        rrFound = 1'b0;
        rrCand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rrCand = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (rrCand >= (IDX_W+1)'(NUM_REQ)) begin
                rrCand = rrCand - (IDX_W+1)'(NUM_REQ);
            end
            if (!rrFound && req_valid_i[rrCand[IDX_W-1:0]]) begin
                rrFound = 1'b1;
                rrIdx   = rrCand[IDX_W-1:0];
            end
        end
    end

    // A held grant overrides round-robin while its requester keeps valid asserted.
    always_comb begin
        if ((state_q == LOCK_HELD) && lockedValid) begin
            grantIdx = lockIdx_q;
            anyValid = 1'b1;
        end else begin
            grantIdx = rrIdx;
            anyValid = rrFound;
        end
    end

    // Lock state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= LOCK_OPEN;
            lockIdx_q <= '0;
        end else begin
            state_q   <= state_d;
            lockIdx_q <= lockIdx_d;
        end
    end

    // Hold the grant whenever an offered operation was not taken by the FPU this cycle.
    always_comb begin
        state_d   = LOCK_OPEN;
        lockIdx_d = lockIdx_q;
        if (fpu_in_valid_o && !fpu_in_ready_i) begin
            state_d   = LOCK_HELD;
            lockIdx_d = grantIdx;
        end
    end

    // Issue forwarding, result steering and status outputs.
    always_comb begin
        req_ready_o    = '0;
        rsp_valid_o    = '0;
        fpu_operands_o = '0;
        fpu_op_o       = '0;
        fpu_rnd_o      = '0;
        rsp_result_o   = fpu_result_i;
        rsp_status_o   = fpu_status_i;
        fpu_in_valid_o = issueAllowed && anyValid;
        if (fpu_in_valid_o) begin
            req_ready_o[grantIdx] = fpu_in_ready_i;
            fpu_operands_o        = req_operands_i[int'(grantIdx)*3*WIDTH +: 3*WIDTH];
            fpu_op_o              = req_op_i[int'(grantIdx)*4 +: 4];
            fpu_rnd_o             = req_rnd_i[int'(grantIdx)*3 +: 3];
        end
        if (flush_i || fifoEmpty) begin
            fpu_out_ready_o = 1'b1;
        end else begin
            rsp_valid_o[headIdx] = fpu_out_valid_i;
            fpu_out_ready_o      = rsp_ready_i[headIdx];
        end
        if (!rst_ni) begin
            fpu_out_ready_o = 1'b0;
        end
        fpu_flush_o = flush_i && rst_ni;
        idle_o      = fifoEmpty && (state_q == LOCK_OPEN) && !fpu_in_valid_o;
    end

    // Next values for pointer, ID FIFO pointers, occupancy count and sticky error.
    always_comb begin
        ptr_d   = ptr_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        err_d   = err_q | lockDropped | strayResult;
        if (issueFire) begin
            ptr_d = (grantIdx == IDX_W'(NUM_REQ-1)) ? '0 : grantIdx + IDX_W'(1);
        end
        if (flush_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (issueFire) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (returnFire) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            if (issueFire && !returnFire) begin
                count_d = count_q + CNT_W'(1);
            end else if (returnFire && !issueFire) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Datapath registers; the ID FIFO entry is written at the issue handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) begin
                idFifo_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            err_q   <= err_d;
            if (issueFire && !flush_i) begin
                idFifo_q[wrPtr_q] <= grantIdx;
            end
        end
    end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// tb_fpu_req_arbiter
// Directed bench: a vector table for single-cycle behaviour, then hand-written
// sequences that drive a small in-order FPU model with configurable latency.
module tb_fpu_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 32;
    localparam int MAX_OUT = 4;
    localparam logic [3:0]  OP_A   = 4'd2;
    localparam logic [3:0]  OP_B   = 4'd5;
    localparam logic [3:0]  OP_MUL = 4'd3;
    localparam logic [31:0] TAG0   = 32'hA000_0000;
    localparam logic [31:0] TAG1   = 32'hA001_0000;

    logic                       clock = 1'b0;
    logic                       resetN;
    logic [NUM_REQ-1:0]         reqValid, reqReady, rspValid, rspReady;
    logic [NUM_REQ*3*WIDTH-1:0] reqOperands;
    logic [NUM_REQ*4-1:0]       reqOp;
    logic [NUM_REQ*3-1:0]       reqRnd;
    logic [WIDTH-1:0]           rspResult, fpuResult;
    logic [4:0]                 rspStatus, fpuStatus;
    logic [3*WIDTH-1:0]         fpuOperands;
    logic [3:0]                 fpuOp;
    logic [2:0]                 fpuRnd;
    logic fpuInValid, fpuInReady, fpuOutValid, fpuOutReady;
    logic flush, fpuFlush, idle, err;

    int checkCount = 0;
    int failCount  = 0;
    logic        useModel = 1'b0;
    int          lat = 1;
    int          cyc = 0;
    logic [31:0] mRes[$];
    int          mDue[$];

    typedef struct {
        logic [1:0] reqValid;
        logic       inReady;
        logic       outValid;
        logic [1:0] rspReady;
        logic       flush;
        logic [1:0] expReqReady;
        logic       expInValid;
        logic [3:0] expOp;
        logic [1:0] expRspValid;
        logic       expOutReady;
        logic       expFlush;
        logic       expIdle;
        logic       expErr;
    } vec_t;

    vec_t vecs[13];

    fpu_req_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_OUT(MAX_OUT)) dut (
        .clk_i          (clock),
        .rst_ni         (resetN),
        .req_valid_i    (reqValid),
        .req_ready_o    (reqReady),
        .req_operands_i (reqOperands),
        .req_op_i       (reqOp),
        .req_rnd_i      (reqRnd),
        .rsp_valid_o    (rspValid),
        .rsp_ready_i    (rspReady),
        .rsp_result_o   (rspResult),
        .rsp_status_o   (rspStatus),
        .fpu_operands_o (fpuOperands),
        .fpu_op_o       (fpuOp),
        .fpu_rnd_o      (fpuRnd),
        .fpu_in_valid_o (fpuInValid),
        .fpu_in_ready_i (fpuInReady),
        .fpu_result_i   (fpuResult),
        .fpu_status_i   (fpuStatus),
        .fpu_out_valid_i(fpuOutValid),
        .fpu_out_ready_o(fpuOutReady),
        .flush_i        (flush),
        .fpu_flush_o    (fpuFlush),
        .idle_o         (idle),
        .err_o          (err)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Normal-number single-precision multiply with truncation, enough for exact products.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) begin
            e = e + 10'd1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic setReq(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [2:0] rnd);
        reqOperands[(r*3)*32 +: 32]   = a;
        reqOperands[(r*3+1)*32 +: 32] = b;
        reqOperands[(r*3+2)*32 +: 32] = 32'h0;
        reqOp[r*4 +: 4]               = op;
        reqRnd[r*3 +: 3]              = rnd;
    endtask

    task automatic applyStimulus(input vec_t v);
        reqValid    = v.reqValid;
        fpuInReady  = v.inReady;
        fpuOutValid = v.outValid;
        rspReady    = v.rspReady;
        flush       = v.flush;
    endtask

    // Samples handshakes late in the cycle, crosses the edge, then advances the FPU model.
    task automatic tick();
        logic        issFire, retFire, flushSeen;
        logic [31:0] res;
        issFire   = fpuInValid && fpuInReady;
        retFire   = fpuOutValid && fpuOutReady;
        flushSeen = flush;
        res = (fpuOp == OP_MUL) ? fmul(fpuOperands[31:0], fpuOperands[63:32]) : fpuOperands[31:0];
        @(posedge clock);
        #1;
        if (useModel) begin
            if (flushSeen) begin
                mRes.delete();
                mDue.delete();
            end else if (retFire && mRes.size() > 0) begin
                void'(mRes.pop_front());
                void'(mDue.pop_front());
            end
            cyc++;
            if (issFire) begin
                mRes.push_back(res);
                mDue.push_back(cyc + lat - 1);
            end
            if (mRes.size() > 0 && mDue[0] <= cyc) begin
                fpuOutValid = 1'b1;
                fpuResult   = mRes[0];
            end else begin
                fpuOutValid = 1'b0;
            end
        end
    endtask

    // Resets DUT and FPU model together; checks the arbiter reports idle while held.
    task automatic doReset();
        @(posedge clock);
        #1;
        resetN      = 1'b0;
        mRes.delete();
        mDue.delete();
        cyc         = 0;
        reqValid    = '0;
        fpuInReady  = 1'b1;
        fpuOutValid = 1'b0;
        rspReady    = 2'b11;
        flush       = 1'b0;
        #4;
        checkOutput("reset idle", 32'(idle), 32'd1);
        @(posedge clock);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{2'b00,1'b1,1'b0,2'b11,1'b0, 2'b00,1'b0,4'h0, 2'b00,1'b1,1'b0,1'b1,1'b0};
        vecs[1]  = '{2'b11,1'b1,1'b0,2'b11,1'b0, 2'b01,1'b1,OP_A, 2'b00,1'b1,1'b0,1'b0,1'b0};
        vecs[2]  = '{2'b11,1'b1,1'b0,2'b11,1'b0, 2'b10,1'b1,OP_B, 2'b00,1'b1,1'b0,1'b0,1'b0};
        vecs[3]  = '{2'b00,1'b1,1'b1,2'b11,1'b0, 2'b00,1'b0,4'h0, 2'b01,1'b1,1'b0,1'b0,1'b0};
        vecs[4]  = '{2'b01,1'b1,1'b1,2'b01,1'b0, 2'b01,1'b1,OP_A, 2'b10,1'b0,1'b0,1'b0,1'b0};
        vecs[5]  = '{2'b00,1'b1,1'b1,2'b10,1'b0, 2'b00,1'b0,4'h0, 2'b10,1'b1,1'b0,1'b0,1'b0};
        vecs[6]  = '{2'b10,1'b0,1'b0,2'b11,1'b0, 2'b00,1'b1,OP_B, 2'b00,1'b1,1'b0,1'b0,1'b0};
        vecs[7]  = '{2'b11,1'b1,1'b0,2'b11,1'b0, 2'b10,1'b1,OP_B, 2'b00,1'b1,1'b0,1'b0,1'b0};
        vecs[8]  = '{2'b11,1'b1,1'b1,2'b11,1'b1, 2'b00,1'b0,4'h0, 2'b00,1'b1,1'b1,1'b0,1'b0};
        vecs[9]  = '{2'b00,1'b1,1'b0,2'b11,1'b0, 2'b00,1'b0,4'h0, 2'b00,1'b1,1'b0,1'b1,1'b0};
        vecs[10] = '{2'b00,1'b1,1'b1,2'b11,1'b0, 2'b00,1'b0,4'h0, 2'b00,1'b1,1'b0,1'b1,1'b0};
        vecs[11] = '{2'b00,1'b1,1'b0,2'b11,1'b0, 2'b00,1'b0,4'h0, 2'b00,1'b1,1'b0,1'b1,1'b1};
        vecs[12] = '{2'b11,1'b1,1'b0,2'b11,1'b0, 2'b01,1'b1,OP_A, 2'b00,1'b1,1'b0,1'b0,1'b1};

        reqOperands = '0;
        reqOp       = '0;
        reqRnd      = '0;
        setReq(0, TAG0, 32'h0, OP_A, 3'd0);
        setReq(1, TAG1, 32'h0, OP_B, 3'd3);
        fpuResult   = 32'h1234_5678;
        fpuStatus   = 5'd0;

        // Power-on reset with every input trying to provoke activity.
        resetN      = 1'b0;
        reqValid    = 2'b11;
        flush       = 1'b1;
        fpuOutValid = 1'b1;
        fpuInReady  = 1'b1;
        rspReady    = 2'b11;
        #12;
        checkOutput("rst reqReady", 32'(reqReady), 32'd0);
        checkOutput("rst inValid", 32'(fpuInValid), 32'd0);
        checkOutput("rst rspValid", 32'(rspValid), 32'd0);
        checkOutput("rst fpuFlush", 32'(fpuFlush), 32'd0);
        checkOutput("rst outReady", 32'(fpuOutReady), 32'd0);
        checkOutput("rst idle", 32'(idle), 32'd1);
        checkOutput("rst err", 32'(err), 32'd0);
        @(posedge clock);
        #1;
        reqValid    = '0;
        flush       = 1'b0;
        fpuOutValid = 1'b0;
        resetN      = 1'b1;

        // Table-driven single-cycle vectors; FPU return side driven directly.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            #4;
            checkOutput($sformatf("vec%0d reqReady", i), 32'(reqReady), 32'(vecs[i].expReqReady));
            checkOutput($sformatf("vec%0d inValid", i), 32'(fpuInValid), 32'(vecs[i].expInValid));
            checkOutput($sformatf("vec%0d fpuOp", i), 32'(fpuOp), 32'(vecs[i].expOp));
            checkOutput($sformatf("vec%0d rspValid", i), 32'(rspValid), 32'(vecs[i].expRspValid));
            checkOutput($sformatf("vec%0d outReady", i), 32'(fpuOutReady), 32'(vecs[i].expOutReady));
            checkOutput($sformatf("vec%0d fpuFlush", i), 32'(fpuFlush), 32'(vecs[i].expFlush));
            checkOutput($sformatf("vec%0d idle", i), 32'(idle), 32'(vecs[i].expIdle));
            checkOutput($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].expErr));
            tick();
        end

        // Both requesters streaming into a 1-cycle FPU: grants alternate, results routed home.
        doReset();
        useModel = 1'b1;
        lat      = 1;
        reqValid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            #4;
            checkOutput($sformatf("alt c%0d reqReady", c), 32'(reqReady), (c % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput($sformatf("alt c%0d idle", c), 32'(idle), 32'd0);
            if (c > 0) begin
                checkOutput($sformatf("alt c%0d rspValid", c), 32'(rspValid), (c % 2 == 1) ? 32'd1 : 32'd2);
                checkOutput($sformatf("alt c%0d result", c), rspResult, (c % 2 == 1) ? TAG0 : TAG1);
            end
            tick();
        end

        // Latency-6 FPU: four issues fill the window, fifth issue the cycle after first return.
        doReset();
        lat      = 6;
        reqValid = 2'b01;
        for (int c = 0; c < 8; c++) begin
            #4;
            checkOutput($sformatf("full c%0d reqReady", c), 32'(reqReady), (c < 4 || c == 7) ? 32'd1 : 32'd0);
            if (c == 6 || c == 7) begin
                checkOutput($sformatf("full c%0d rspValid", c), 32'(rspValid), 32'd1);
            end
            tick();
        end

        // Reset with operations in flight, then a stalled grant that must not be stolen.
        doReset();
        lat      = 3;
        reqValid = 2'b01;
        #4;
        checkOutput("lock c0 reqReady", 32'(reqReady), 32'd1);
        tick();
        fpuInReady = 1'b0;
        for (int c = 1; c < 4; c++) begin
            if (c == 2) reqValid = 2'b11;
            #4;
            checkOutput($sformatf("lock c%0d reqReady", c), 32'(reqReady), 32'd0);
            checkOutput($sformatf("lock c%0d inValid", c), 32'(fpuInValid), 32'd1);
            checkOutput($sformatf("lock c%0d fpuOp", c), 32'(fpuOp), 32'(OP_A));
            tick();
        end
        fpuInReady = 1'b1;
        #4;
        checkOutput("lock c4 reqReady", 32'(reqReady), 32'd1);
        tick();
        #4;
        checkOutput("lock c5 reqReady", 32'(reqReady), 32'd2);
        checkOutput("lock c5 fpuOp", 32'(fpuOp), 32'(OP_B));
        tick();

        // Result for req1 back-pressured for two cycles.
        doReset();
        lat      = 1;
        reqValid = 2'b10;
        rspReady = 2'b01;
        #4;
        checkOutput("bp c0 reqReady", 32'(reqReady), 32'd2);
        tick();
        reqValid = 2'b00;
        for (int c = 1; c < 3; c++) begin
            #4;
            checkOutput($sformatf("bp c%0d rspValid", c), 32'(rspValid), 32'd2);
            checkOutput($sformatf("bp c%0d outReady", c), 32'(fpuOutReady), 32'd0);
            checkOutput($sformatf("bp c%0d result", c), rspResult, TAG1);
            checkOutput($sformatf("bp c%0d idle", c), 32'(idle), 32'd0);
            tick();
        end
        rspReady = 2'b11;
        #4;
        checkOutput("bp c3 outReady", 32'(fpuOutReady), 32'd1);
        checkOutput("bp c3 rspValid", 32'(rspValid), 32'd2);
        tick();
        #4;
        checkOutput("bp c4 idle", 32'(idle), 32'd1);
        checkOutput("bp c4 rspValid", 32'(rspValid), 32'd0);
        tick();

        // Flush with three operations in flight, then a stray result.
        doReset();
        lat      = 10;
        reqValid = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #4;
            checkOutput($sformatf("flush c%0d reqReady", c), 32'(reqReady), 32'd1);
            tick();
        end
        reqValid = 2'b00;
        flush    = 1'b1;
        #4;
        checkOutput("flush fpuFlush", 32'(fpuFlush), 32'd1);
        checkOutput("flush inValid", 32'(fpuInValid), 32'd0);
        checkOutput("flush idle", 32'(idle), 32'd0);
        tick();
        flush = 1'b0;
        #4;
        checkOutput("after flush idle", 32'(idle), 32'd1);
        checkOutput("after flush err", 32'(err), 32'd0);
        tick();
        useModel    = 1'b0;
        fpuOutValid = 1'b1;
        #4;
        checkOutput("stray outReady", 32'(fpuOutReady), 32'd1);
        checkOutput("stray rspValid", 32'(rspValid), 32'd0);
        tick();
        fpuOutValid = 1'b0;
        #4;
        checkOutput("stray err", 32'(err), 32'd1);
        tick();

        // 1.5 * 2.0 issued by req1 comes back as 3.0 on req1 only.
        doReset();
        useModel = 1'b1;
        lat      = 1;
        setReq(1, 32'h3FC0_0000, 32'h4000_0000, OP_MUL, 3'd0);
        reqValid = 2'b10;
        #4;
        checkOutput("mul reqReady", 32'(reqReady), 32'd2);
        checkOutput("mul fpuOp", 32'(fpuOp), 32'(OP_MUL));
        tick();
        reqValid = 2'b00;
        #4;
        checkOutput("mul rspValid", 32'(rspValid), 32'd2);
        checkOutput("mul result", rspResult, 32'h4040_0000);
        checkOutput("mul status", 32'(rspStatus), 32'd0);
        tick();

        // Locked requester withdrawing its request raises the sticky error.
        doReset();
        lat        = 1;
        reqValid   = 2'b01;
        fpuInReady = 1'b0;
        #4;
        checkOutput("drop c0 inValid", 32'(fpuInValid), 32'd1);
        checkOutput("drop c0 reqReady", 32'(reqReady), 32'd0);
        tick();
        reqValid = 2'b00;
        #4;
        checkOutput("drop c1 err", 32'(err), 32'd0);
        checkOutput("drop c1 idle", 32'(idle), 32'd0);
        tick();
        #4;
        checkOutput("drop c2 err", 32'(err), 32'd1);
        checkOutput("drop c2 idle", 32'(idle), 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/fpu_req_arbiter.md
FPU_REQ_ARBITER -- requirements
Module: fpu_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing one fpnew_top; legal range 2..8.
REQ-002 Parameter WIDTH, default 32: operand/result width (RV32F).
REQ-003 Parameter MAX_OUT, default 4: maximum operations in flight inside the FPU; power of two, at least 2.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  in  NUM_REQ  per-requester operation valid.
REQ-007 req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_operands_i  in  NUM_REQ x 3 x WIDTH  per-requester operands.
REQ-009 req_op_i  in  NUM_REQ x 4  per-requester fpnew_pkg::operation_e; req_rnd_i  in  NUM_REQ x 3  per-requester roundmode_e.
REQ-010 rsp_valid_o  out  NUM_REQ  result valid, one-hot or zero; rsp_ready_i  in  NUM_REQ  requester accepts result.
REQ-011 rsp_result_o  out  WIDTH; rsp_status_o  out  5 ({NV,DZ,OF,UF,NX}); shared by all requesters.
REQ-012 fpu_operands_o  out  3 x WIDTH; fpu_op_o  out  4; fpu_rnd_o  out  3; fpu_in_valid_o  out  1; fpu_in_ready_i  in  1.
REQ-013 fpu_result_i  in  WIDTH; fpu_status_i  in  5; fpu_out_valid_i  in  1; fpu_out_ready_o  out  1.
REQ-014 flush_i  in  1 abort; fpu_flush_o  out  1; idle_o  out  1; err_o  out  1 sticky protocol error.

Function
REQ-015 Arbitration round-robin: starting at index ptr, lowest valid index at or after ptr (wrapping) wins; ptr resets to 0.
REQ-016 Issue allowed only when outstanding count < MAX_OUT and flush_i low; when blocked fpu_in_valid_o and all req_ready_o are 0.
REQ-017 fpu_in_valid_o = issue allowed and any req_valid_i; fpu_operands_o/op/rnd driven from the granted requester; otherwise all zero.
REQ-018 Grant lock: once fpu_in_valid_o is high and fpu_in_ready_i low, grant is registered and held until handshake completes, regardless of other requests.
REQ-019 req_ready_o[g] = fpu_in_ready_i for granted g only; issue handshake = fpu_in_valid_o and fpu_in_ready_i; zero added latency (combinational forward).
REQ-020 On issue handshake: push g into ID FIFO (depth MAX_OUT), ptr <= (g+1) mod NUM_REQ, lock cleared.
REQ-021 FPU returns results in order; head of ID FIFO names destination h.
REQ-022 FIFO non-empty: rsp_valid_o[h] = fpu_out_valid_i, rsp_result_o/status_o = fpu_result_i/status_i, fpu_out_ready_o = rsp_ready_i[h]; other rsp_valid_o bits 0.
REQ-023 Return handshake (fpu_out_valid_i and fpu_out_ready_o) pops FIFO.
REQ-024 Count: +1 on issue only, -1 on return only, unchanged on both same cycle; when full, issue blocked even if a pop occurs same cycle.
REQ-025 fpu_out_valid_i with FIFO empty: fpu_out_ready_o = 1 (drain), no rsp_valid_o, err_o set until reset.
REQ-026 Requester deasserting req_valid_i while locked and not accepted sets err_o; lock released.
REQ-027 flush_i high: fpu_flush_o = 1 same cycle, FIFO/count/lock cleared next edge, ptr kept, no issue that cycle; in-flight results discarded.
REQ-028 idle_o = count==0 and no lock and fpu_in_valid_o low.

Reset
REQ-029 rst_ni low asynchronously clears FIFO, count, ptr, lock, err_o; req_ready_o, rsp_valid_o, fpu_in_valid_o, fpu_flush_o = 0; fpu_out_ready_o = 0; idle_o = 1.
REQ-030 Reset mid-operation discards all in-flight IDs; the bench also resets the FPU simultaneously.
REQ-031 First issue possible the cycle after rst_ni deasserts.

Verification
REQ-032 Both requesters valid continuously, FPU always ready, 1-cycle FPU model -> grants alternate 0,1,0,1; each result routed to its issuer; idle_o=0 during traffic.
REQ-033 MAX_OUT=4, FPU latency 6, req0 streaming -> exactly 4 issues, then req_ready_o=0 until first return; 5th issue the cycle after first return.
REQ-034 fpu_in_ready_i low 3 cycles while req0 granted, req1 raises valid -> req0 held, req1 not granted until req0 accepted; ptr then 1.
REQ-035 Results return to req1 with rsp_ready_i[1]=0 for 2 cycles -> fpu_out_ready_o=0, result stable, FIFO not popped.
REQ-036 3 ops in flight, flush_i pulsed -> fpu_flush_o=1 that cycle, count=0 and idle_o=1 next cycle; later stray fpu_out_valid_i -> err_o=1.
REQ-037 Issue 1.5*2.0 (0x3FC00000,0x40000000) from req1 -> rsp_result_o=0x40400000, status 0, on rsp_valid_o[1] only.
